// File: rtl/sram_controller_pkg.sv
// Shared types and widths for the 32-bit-over-16-bit SRAM controller.
// Holds the FSM state enum and the default SRAM window base address.
package sram_controller_pkg;

    localparam int SRAM_AW    = 18;
    localparam int SRAM_DW    = 16;
    localparam int WORD_IDX_W = SRAM_AW - 1;
    localparam int DATA_W     = 32;
    localparam int CNT_W      = 4;

    localparam logic [DATA_W-1:0] DEFAULT_BASE_ADDR = 32'd1024;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_e;

endpackage

// File: rtl/sram_phase_counter.sv
// Cycle counter for one SRAM half-access; last_o flags the final cycle.
// Clears itself on the last cycle and whenever it is not enabled.
module sram_phase_counter
    import sram_controller_pkg::*;
#(
    parameter int ACCESS_CYCLES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic last_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    assign last_o = en_i && (cnt_q == CNT_W'(ACCESS_CYCLES - 1));

    always_comb begin
        cnt_d = '0;
        if (en_i && !last_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/sram_controller.sv
// MEM-stage load/store port to a 16-bit asynchronous SRAM (two halfword phases).
// Define SRAM_BOUNDS_CHECK_EN to short-circuit requests outside the SRAM window.
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int                ACCESS_CYCLES = 2,
    parameter logic [DATA_W-1:0] BASE_ADDR     = DEFAULT_BASE_ADDR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wrEn,
    input  logic               rdEn,
    input  logic [DATA_W-1:0]  address,
    input  logic [DATA_W-1:0]  writeData,
    output logic [DATA_W-1:0]  readData,
    output logic               ready,
    inout  wire  [SRAM_DW-1:0] sramDQ,
    output logic [SRAM_AW-1:0] sramAddr,
    output logic               sramWE_N,
    output logic               sramOE_N,
    output logic               sramCE_N,
    output logic               sramUB_N,
    output logic               sramLB_N
);

    state_e                  state_q, state_d;
    logic                    isWr_q;
    logic [WORD_IDX_W-1:0]   idx_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [SRAM_DW-1:0]      rdLo_q;
    logic [DATA_W-1:0]       readData_q;

    logic                    req;
    logic                    oob;
    logic                    last;
    logic                    inPhase;
    logic [DATA_W-1:0]       addrAl;
    logic [WORD_IDX_W-1:0]   wordIdx;
    logic                    dqOe;
    logic [SRAM_DW-1:0]      dqOut;

    assign req     = rdEn || wrEn;
    assign addrAl  = address & 32'hFFFF_FFFC;
    assign wordIdx = WORD_IDX_W'((addrAl - BASE_ADDR) >> 2);
    assign inPhase = (state_q == LOW) || (state_q == HIGH);

`ifdef SRAM_BOUNDS_CHECK_EN
    logic [DATA_W-1:0] span;
    assign span = addrAl - BASE_ADDR;
    assign oob  = (addrAl < BASE_ADDR) || ((span >> 18) != '0);
`else
    assign oob  = 1'b0;
`endif

    sram_phase_counter #(
        .ACCESS_CYCLES(ACCESS_CYCLES)
    ) u_phase (
        .clk   (clk),
        .rst   (rst),
        .en_i  (inPhase),
        .last_o(last)
    );

    assign sramDQ   = dqOe ? dqOut : {SRAM_DW{1'bz}};
    assign sramCE_N = 1'b0;
    assign sramUB_N = 1'b0;
    assign sramLB_N = 1'b0;
    assign readData = readData_q;

    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        sramAddr = '0;
        sramWE_N = 1'b1;
        sramOE_N = 1'b1;
        dqOe     = 1'b0;
        dqOut    = '0;
        unique case (state_q)
            IDLE: begin
                ready = !req;
                if (req) begin
                    state_d = oob ? DONE : LOW;
                end
            end
            LOW: begin
                sramAddr = {idx_q, 1'b0};
                dqOut    = wdata_q[15:0];
                dqOe     = isWr_q;
                sramWE_N = !(isWr_q && !last);
                sramOE_N = isWr_q;
                if (last) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                sramAddr = {idx_q, 1'b1};
                dqOut    = wdata_q[31:16];
                dqOe     = isWr_q;
                sramWE_N = !(isWr_q && !last);
                sramOE_N = isWr_q;
                if (last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                ready   = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured once in IDLE so later input churn is ignored.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            isWr_q     <= 1'b0;
            idx_q      <= '0;
            wdata_q    <= '0;
            rdLo_q     <= '0;
            readData_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == IDLE && req) begin
                isWr_q  <= wrEn;
                idx_q   <= wordIdx;
                wdata_q <= writeData;
                if (oob && !wrEn) begin
                    readData_q <= '0;
                end
            end
            if (state_q == LOW && last && !isWr_q) begin
                rdLo_q <= sramDQ;
            end
            if (state_q == HIGH && last && !isWr_q) begin
                readData_q <= {sramDQ, rdLo_q};
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Bench for sram_controller: directed and random accesses against a word-level model.
// Build with SRAM_BOUNDS_CHECK_EN to also exercise the out-of-window path.
module tb_sram_controller;

    localparam int          AC   = 2;
    localparam logic [31:0] BASE = 32'd1024;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        wrEn = 1'b0;
    logic        rdEn = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] writeData = '0;
    logic [31:0] readData;
    logic        ready;
    tri1  [15:0] sramDQ;
    logic [17:0] sramAddr;
    logic        sramWE_N, sramOE_N, sramCE_N, sramUB_N, sramLB_N;

    int nAsserts = 0;
    int nFails   = 0;

    logic [15:0] sram [0:262143];
    logic [31:0] refMem [logic [16:0]];
    logic [31:0] expRd;

    int          lowCyc, weCyc, oeCyc;
    logic [17:0] trAddr [$];
    logic [15:0] trDq [$];

    sram_controller #(
        .ACCESS_CYCLES(AC),
        .BASE_ADDR    (BASE)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .wrEn     (wrEn),
        .rdEn     (rdEn),
        .address  (address),
        .writeData(writeData),
        .readData (readData),
        .ready    (ready),
        .sramDQ   (sramDQ),
        .sramAddr (sramAddr),
        .sramWE_N (sramWE_N),
        .sramOE_N (sramOE_N),
        .sramCE_N (sramCE_N),
        .sramUB_N (sramUB_N),
        .sramLB_N (sramLB_N)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: drives the bus while OE_N is low, stores while WE_N is low.
    assign sramDQ = (!sramOE_N) ? sram[sramAddr] : 16'bz;
    always @(posedge clk) begin
        if (!sramWE_N) sram[sramAddr] <= sramDQ;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 64 && !ready; i++) begin
            @(negedge clk); #1;
        end
        chk(tag, 32'(ready), 32'd1);
    endtask

    task automatic access(input logic wr, input logic rd, input logic [31:0] a,
                          input logic [31:0] d, input bit scramble);
        @(negedge clk);
        wrEn = wr; rdEn = rd; address = a; writeData = d;
        lowCyc = 0; weCyc = 0; oeCyc = 0;
        trAddr.delete(); trDq.delete();
        #1;
        for (int i = 0; i < 64 && !ready; i++) begin
            lowCyc++;
            if (!sramWE_N) weCyc++;
            if (!sramOE_N) oeCyc++;
            trAddr.push_back(sramAddr);
            trDq.push_back(sramDQ);
            @(negedge clk);
            if (scramble) begin
                address = $urandom; writeData = $urandom;
                wrEn = 1'b0; rdEn = 1'b0;
            end
            #1;
        end
        chk("access_timeout", 32'(ready), 32'd1);
        wrEn = 1'b0; rdEn = 1'b0;
    endtask

    task automatic do_op(input logic wr, input logic rd, input logic [31:0] a,
                         input logic [31:0] d, input bit scramble);
        logic [16:0] idx;
        idx = 17'(((a & 32'hFFFF_FFFC) - BASE) >> 2);
        access(wr, rd, a, d, scramble);
        chk("busy_cycles", 32'(lowCyc), 32'(2 * AC + 1));
        if (wr) begin
            chk("wr_we_cycles", 32'(weCyc), 32'(2 * (AC - 1)));
            chk("wr_oe_cycles", 32'(oeCyc), 32'd0);
            chk("wr_addr_lo", 32'(trAddr[1]), 32'({idx, 1'b0}));
            chk("wr_addr_lo_hold", 32'(trAddr[AC]), 32'({idx, 1'b0}));
            chk("wr_addr_hi", 32'(trAddr[AC + 1]), 32'({idx, 1'b1}));
            chk("wr_dq_lo", 32'(trDq[1]), 32'(d[15:0]));
            chk("wr_dq_lo_hold", 32'(trDq[AC]), 32'(d[15:0]));
            chk("wr_dq_hi", 32'(trDq[AC + 1]), 32'(d[31:16]));
            refMem[idx] = d;
        end else begin
            chk("rd_we_cycles", 32'(weCyc), 32'd0);
            chk("rd_oe_cycles", 32'(oeCyc), 32'(2 * AC));
            chk("rd_addr_lo", 32'(trAddr[1]), 32'({idx, 1'b0}));
            chk("rd_addr_hi", 32'(trAddr[AC + 1]), 32'({idx, 1'b1}));
            expRd = refMem[idx];
        end
        chk("read_data", readData, expRd);
    endtask

    initial begin
        int          w;
        logic        wr;
        logic [31:0] d;

        expRd = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_readData", readData, 32'd0);
        chk("rst_we", 32'(sramWE_N), 32'd1);
        chk("rst_oe", 32'(sramOE_N), 32'd1);
        chk("rst_dq_released", 32'(sramDQ), 32'h0000_FFFF);
        chk("rst_addr", 32'(sramAddr), 32'd0);
        chk("strobes_tied", 32'({sramCE_N, sramUB_N, sramLB_N}), 32'd0);
        rst = 1'b1;

        do_op(1'b1, 1'b0, 32'd1028, 32'hDEAD_BEEF, 1'b0);
        chk("wr_addr_first", 32'(trAddr[1]), 32'd2);
        chk("wr_addr_second", 32'(trAddr[AC + 1]), 32'd3);
        do_op(1'b0, 1'b1, 32'd1028, 32'h0, 1'b0);
        chk("rd_deadbeef", readData, 32'hDEAD_BEEF);

        do_op(1'b1, 1'b1, 32'd1024, 32'h1234_5678, 1'b0);
        do_op(1'b0, 1'b1, 32'd1024, 32'h0, 1'b0);
        chk("both_en_is_write", readData, 32'h1234_5678);

        do_op(1'b1, 1'b0, 32'd1040, 32'hCAFE_F00D, 1'b1);
        do_op(1'b0, 1'b1, 32'd1043, 32'h0, 1'b1);

        // A request held through DONE starts a fresh access.
        @(negedge clk);
        rdEn = 1'b1; address = 32'd1028;
        #1;
        wait_ready("held_first_done");
        @(negedge clk); #1;
        chk("held_idle_busy", 32'(ready), 32'd0);
        @(negedge clk); #1;
        chk("held_restart_oe", 32'(sramOE_N), 32'd0);
        rdEn = 1'b0;
        wait_ready("held_second_done");
        chk("held_read_data", readData, 32'hDEAD_BEEF);
        expRd = 32'hDEAD_BEEF;

        for (int k = 0; k < 16; k++) begin
            d = $urandom;
            do_op(1'b1, 1'($urandom_range(0, 1)),
                  BASE + 32'(4 * k) + 32'($urandom_range(0, 3)), d, 1'b0);
        end
        for (int k = 0; k < 30; k++) begin
            w  = $urandom_range(0, 15);
            wr = 1'($urandom_range(0, 1));
            d  = $urandom;
            do_op(wr, !wr || 1'($urandom_range(0, 1)),
                  BASE + 32'(4 * w) + 32'($urandom_range(0, 3)), d,
                  1'($urandom_range(0, 1)));
        end

`ifndef SRAM_BOUNDS_CHECK_EN
        do_op(1'b1, 1'b0, BASE + 32'(4 * (131072 + 7)), 32'h0BAD_F00D, 1'b0);
        do_op(1'b0, 1'b1, BASE + 32'd28, 32'h0, 1'b0);
        chk("wrap_alias", readData, 32'h0BAD_F00D);
`endif

        // Reset during the HIGH phase of a write aborts it.
        @(negedge clk);
        wrEn = 1'b1; address = BASE + 32'd12; writeData = 32'h5555_AAAA;
        repeat (AC + 1) @(negedge clk);
        chk("pre_rst_in_high", 32'(sramAddr), 32'd7);
        rst = 1'b0; wrEn = 1'b0;
        @(posedge clk); #1;
        chk("abort_ready", 32'(ready), 32'd1);
        chk("abort_we", 32'(sramWE_N), 32'd1);
        chk("abort_oe", 32'(sramOE_N), 32'd1);
        chk("abort_dq_released", 32'(sramDQ), 32'h0000_FFFF);
        chk("abort_addr", 32'(sramAddr), 32'd0);
        chk("abort_readData", readData, 32'd0);
        rst = 1'b1;
        refMem.delete(17'd3);
        expRd = '0;
        do_op(1'b0, 1'b1, BASE + 32'd8, 32'h0, 1'b0);

`ifdef SRAM_BOUNDS_CHECK_EN
        access(1'b0, 1'b1, 32'd512, 32'h0, 1'b0);
        chk("oob_rd_busy", 32'(lowCyc), 32'd1);
        chk("oob_rd_we", 32'(weCyc), 32'd0);
        chk("oob_rd_oe", 32'(oeCyc), 32'd0);
        chk("oob_rd_data", readData, 32'd0);
        expRd = '0;
        access(1'b1, 1'b0, BASE + 32'(4 * 65536), 32'h7777_7777, 1'b0);
        chk("oob_wr_busy", 32'(lowCyc), 32'd1);
        chk("oob_wr_we", 32'(weCyc), 32'd0);
        chk("oob_wr_data_kept", readData, expRd);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/sram_controller.md
SRAM_CONTROLLER -- requirements
Module: sram_controller

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-low reset; the clock port is named clk and the reset port is named rst.
REQ-002 Parameter ACCESS_CYCLES, default 2, SHALL set the clock cycles per 16-bit SRAM half-access; legal range 2..15.
REQ-003 Parameter BASE_ADDR, default 1024, SHALL set the byte address mapped to SRAM halfword 0.
REQ-004 clk  in  1  system clock.
REQ-005 rst  in  1  synchronous reset, active low.
REQ-006 wrEn  in  1  store request from the MEM stage.
REQ-007 rdEn  in  1  load request from the MEM stage.
REQ-008 address  in  32  byte address from the ALU result.
REQ-009 writeData  in  32  store value.
REQ-010 readData  out  32  load result.
REQ-011 ready  out  1  high when there is no pending request or the current access completes this cycle; used as the pipeline freeze.
REQ-012 sramDQ  inout  16  SRAM data bus.
REQ-013 sramAddr  out  18  SRAM halfword address.
REQ-014 sramWE_N, sramOE_N, sramCE_N, sramUB_N, sramLB_N  out  1 each  active-low SRAM strobes.

Function
REQ-015 FSM states SHALL be IDLE, LOW, HIGH and DONE; all state changes occur on the clk rising edge.
REQ-016 IDLE SHALL go to LOW when rdEn or wrEn is high; otherwise it stays in IDLE.
REQ-017 LOW SHALL last ACCESS_CYCLES cycles, then go to HIGH; HIGH SHALL last ACCESS_CYCLES cycles, then go to DONE; DONE SHALL last one cycle, then go to IDLE.
REQ-018 ready SHALL be combinational: 1 in IDLE with no request, 1 in DONE, 0 otherwise.
REQ-019 For a request first seen in IDLE, ready SHALL be low for exactly 2*ACCESS_CYCLES+1 cycles.
REQ-020 wordIndex = (address - BASE_ADDR) >> 2, truncated to 17 bits.
REQ-021 The LOW phase SHALL drive sramAddr = {wordIndex,1'b0}; the HIGH phase SHALL drive sramAddr = {wordIndex,1'b1}.
REQ-022 Write phases: sramDQ SHALL carry writeData[15:0] in LOW and writeData[31:16] in HIGH.
REQ-023 In write phases, sramWE_N SHALL be low in every cycle except the last cycle of each phase, which provides address and data hold.
REQ-024 In read phases, sramOE_N SHALL be low and sramDQ SHALL be high-Z.
REQ-025 The low half SHALL be latched in the last LOW cycle and the high half in the last HIGH cycle.
REQ-026 readData SHALL update on entry to DONE and hold until the next read completes.
REQ-027 sramCE_N, sramUB_N and sramLB_N SHALL be held at 0.
REQ-028 In IDLE and DONE: sramWE_N=1, sramOE_N=1, sramDQ high-Z.
REQ-029 If rdEn and wrEn are both high, the request SHALL be executed as a write.
REQ-030 Request inputs SHALL be sampled only in IDLE; changes during LOW, HIGH or DONE are ignored.
REQ-031 A request still asserted in IDLE after DONE SHALL start a new access (no request memory).
REQ-032 Address bits [1:0] SHALL be ignored.

Reset
REQ-033 While rst=0 at a clock edge: state goes to IDLE, phase counter goes to 0, readData goes to 0, sramWE_N=1, sramOE_N=1, sramAddr=0, sramDQ high-Z.
REQ-034 Reset asserted mid-access SHALL abort the access with no further SRAM strobes; the halfword being written may be corrupt.

Configuration
REQ-035 With SRAM_BOUNDS_CHECK_EN defined, a request with address < BASE_ADDR or wordIndex > 65535 SHALL go directly from IDLE to DONE.
REQ-036 Such an out-of-range request SHALL issue no strobes; if it is a read, readData SHALL be set to 0.
REQ-037 Without SRAM_BOUNDS_CHECK_EN, every request SHALL follow the full FSM and the address wraps modulo 2^17 words.

Structure
REQ-038 The shared package SHALL hold the state enum, the BASE_ADDR default and the SRAM address and data widths.
REQ-039 The phase counter with its last-cycle flag SHALL be a sub-module named sram_phase_counter.

Verification
REQ-040 Reset with rst=0 for 2 cycles -> ready=1, readData=0, sramWE_N=1, sramDQ=Z.
REQ-041 Write 0xDEADBEEF to 1028 with ACCESS_CYCLES=2 -> sramAddr 2 then 3, DQ 0xBEEF then 0xDEAD, WE_N low 1 cycle per phase, ready low 5 cycles.
REQ-042 Read 1028 after that write -> readData=0xDEADBEEF in DONE, OE_N low 4 cycles.
REQ-043 rdEn=wrEn=1 at 1024 with data 0x12345678 -> write performed; a subsequent read of 1024 returns 0x12345678.
REQ-044 rst=0 during the HIGH phase of a write -> next cycle IDLE, WE_N=1, DQ=Z, ready=1.
REQ-045 SRAM_BOUNDS_CHECK_EN defined, read address 512 -> ready low 1 cycle, readData=0, no strobe toggles.
